// File: rtl/evt_window_sched_pkg.sv
// rtl/evt_window_sched_pkg.sv - shared types and width helpers for the windowed event scheduler
package evt_window_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CHW = chan_width(4);

endpackage

// File: rtl/evt_window_sched_if.sv
// rtl/evt_window_sched_if.sv - snapshot readout stream between scheduler and consumer
interface evt_window_sched_if #(
    parameter int N_CH = 4,
    parameter int CW   = 16
);
    localparam int CH_W = evt_window_sched_pkg::chan_width(N_CH);

    logic [CW-1:0]   data_out;
    logic [CH_W-1:0] chan_out;
    logic            valid_out;
    logic            ready_in;
    logic            last_out;

    modport master (
        output data_out,
        output chan_out,
        output valid_out,
        output last_out,
        input  ready_in
    );

    modport slave (
        input  data_out,
        input  chan_out,
        input  valid_out,
        input  last_out,
        output ready_in
    );
endinterface

// File: rtl/evt_window_sched_sat_counter.sv
// rtl/evt_window_sched_sat_counter.sv - saturating event counter with sync clear
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          clr_in,
    input  logic          inc_in,
    output logic [CW-1:0] next_out
);
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] inc_val;

    // next_out ignores the clear so a boundary snapshot still sees this cycle's event
    always_comb begin
        inc_val = count_q;
        if (inc_in && (count_q != {CW{1'b1}})) begin
            inc_val = count_q + CW'(1);
        end
        count_d = clr_in ? '0 : inc_val;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign next_out = inc_val;
endmodule

// File: rtl/evt_window_sched.sv
// rtl/evt_window_sched.sv - window timer, boundary snapshot and per-channel readout stream
module evt_window_sched
    import evt_window_sched_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int CW            = 16,
    parameter int WINDOW_CYCLES = 1000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable_in,
    input  logic [N_CH-1:0]       evt_in,
    output logic                  window_done_out,
    output logic                  overrun_out,
    evt_window_sched_if.master    m_if
);
    localparam int CH_W = chan_width(N_CH);
    localparam int TW   = $clog2(WINDOW_CYCLES);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CH_W-1:0] chan_q, chan_d;
    logic [CW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            wdone_q, wdone_d;
    logic            ovr_q, ovr_d;
    logic [CW-1:0]   snap_q [N_CH];
    logic [CW-1:0]   snap_d [N_CH];
    logic [CW-1:0]   cnt_next [N_CH];

    logic boundary;
    logic cnt_clr;
    logic hs;
    logic last_hs;
    logic load;

    assign boundary = enable_in && (timer_q == TW'(WINDOW_CYCLES - 1));
    assign cnt_clr  = !enable_in || boundary;
    assign hs       = valid_q && m_if.ready_in;
    assign last_hs  = hs && last_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sat_counter #(.CW(CW)) u_cnt (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .clr_in   (cnt_clr),
            .inc_in   (enable_in && evt_in[i]),
            .next_out (cnt_next[i])
        );
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        ovr_d   = ovr_q;
        snap_d  = snap_q;
        wdone_d = boundary;
        timer_d = cnt_clr ? '0 : timer_q + TW'(1);

        // A boundary is taken unless a drain is still in progress; finishing the
        // drain on the boundary cycle frees the snapshot registers in time.
        load = boundary && ((state_q != DRAIN) || last_hs);
        if (boundary && !load) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable_in) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable_in) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (last_q) begin
                        state_d = enable_in ? RUN : IDLE;
                        chan_d  = '0;
                    end else begin
                        chan_d = chan_q + CH_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = DRAIN;
            chan_d  = '0;
            for (int i = 0; i < N_CH; i++) begin
                snap_d[i] = cnt_next[i];
            end
        end

        valid_d = (state_d == DRAIN);
        last_d  = valid_d && (chan_d == CH_W'(N_CH - 1));
        data_d  = snap_d[chan_d];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            timer_q <= '0;
            chan_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            wdone_q <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            wdone_q <= wdone_d;
            ovr_q   <= ovr_d;
            for (int i = 0; i < N_CH; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign m_if.data_out   = data_q;
    assign m_if.chan_out   = chan_q;
    assign m_if.valid_out  = valid_q;
    assign m_if.last_out   = last_q;
    assign window_done_out = wdone_q;
    assign overrun_out     = ovr_q;
endmodule

// File: doc/evt_window_sched.md
# evt_window_sched

Windowed sampling scheduler for a bank of per-channel event counters. It runs a free-running window timer and, at each window boundary, snapshots and clears every channel's count. It then streams the snapshot out one channel at a time over a valid/ready handshake. It sits between raw event sources (simulator pulse strobes) and the host-readout/display path, turning event counts into per-window rates.

## Interface
- N_CH, default 4: number of event channels (≥2).
- CW, default 16: counter and output data width.
- WINDOW_CYCLES, default 1000: window length in clk_in cycles (≥ N_CH+2).

- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  reset, synchronous, active-low.
- enable_in  input  1  1 = windows run; 0 = timer and counters held at 0.
- evt_in  input  N_CH  per-channel event strobe, one count per cycle high.
- data_out  output  CW  snapshot count for chan_out.
- chan_out  output  $clog2(N_CH)  channel index of data_out.
- valid_out  output  1  data_out/chan_out valid.
- ready_in  input  1  consumer accepts when valid_out && ready_in.
- last_out  output  1  high with valid_out when chan_out == N_CH-1.
- window_done_out  output  1  one-cycle pulse on each window boundary.
- overrun_out  output  1  sticky; a boundary snapshot was dropped.

## Operation
- States: IDLE (enable low or after reset), RUN (counting, no output pending), DRAIN (counting, streaming snapshot).
- Reset (rst_in == 0): state IDLE; timer, all counters, snapshot regs 0; data_out 0, chan_out 0, valid_out 0, last_out 0, window_done_out 0, overrun_out 0.
- IDLE -> RUN when enable_in == 1. RUN/DRAIN -> IDLE when enable_in == 0 and no drain is pending. With enable low during DRAIN, the drain completes and then the block goes to IDLE. Timer and counters are held at 0 whenever enable_in == 0.
- Counting: channel i increments by 1 on each enabled cycle with evt_in[i] = 1. It saturates at 2^CW-1 and never wraps.
- Timer counts 0..WINDOW_CYCLES-1, then wraps to 0. The boundary cycle is timer == WINDOW_CYCLES-1 with enable high.
- On the boundary cycle:
  - snapshot[i] <= sat(count[i] + evt_in[i]); the event on the boundary cycle belongs to the closing window.
  - All counters <= 0.
  - window_done_out pulses on the following cycle.
- Snapshot acceptance:
  - In RUN: snapshot loaded, go to DRAIN with chan 0.
  - In DRAIN: snapshot dropped, overrun_out <= 1, current drain continues unaffected.
  - Exception: if the boundary coincides with the handshake of the last channel, the new snapshot is accepted, not an overrun.
- DRAIN: present channels 0..N_CH-1 in order. Each handshake advances chan_out by 1. The handshake on chan N_CH-1 returns to RUN (or IDLE if enable_in == 0).
- overrun_out clears only on reset.

## Timing
- Boundary at cycle T -> valid_out = 1, chan_out = 0, data_out = snapshot[0] at T+1; window_done_out high at T+1 only.
- Output registers update one cycle after each handshake. Back-to-back ready_in = 1 drains all channels in N_CH cycles.
- valid_out, once high, stays high with stable data_out/chan_out until the handshake (no retraction).
- Last handshake at cycle H with no boundary: valid_out = 0 at H+1.
- Last handshake coincides with boundary: valid_out stays 1, chan_out = 0, new data at H+1.
- The first window after enable rises spans exactly WINDOW_CYCLES enabled cycles.

## Structure
- Package evt_window_sched_pkg:
  - state enum (IDLE, RUN, DRAIN)
  - width helper localparam CHW = $clog2(N_CH)
- Sub-module sat_counter: one per channel, generate loop, CW-bit saturating counter with sync clear and increment enable. It exposes its next value so the boundary snapshot includes the boundary-cycle event.
- Top level holds the timer, FSM, snapshot array, and output mux/registers.

## Test plan
- Reset mid-drain (N_CH = 4, rst_in low one cycle while valid_out = 1, chan 2) -> all outputs 0 next cycle; state IDLE; counts restart from 0.
- WINDOW_CYCLES = 10, evt_in[0] high 3 cycles, evt_in[3] high every cycle, ready_in = 1:
  - window_done_out pulses once.
  - Stream (0,3), (1,0), (2,0), (3,10) on 4 consecutive cycles.
  - last_out high only on chan 3.
- CW = 4, evt_in[1] held high for a 40-cycle window -> chan 1 reports 15 (saturated), no wrap.
- ready_in = 0 for 2 full windows after the first boundary:
  - overrun_out = 1 and stays set.
  - Draining then yields the first window's data unchanged.
- Last-channel handshake on the same cycle as a boundary -> valid_out remains 1, chan_out = 0 with new data; overrun_out stays 0.
- enable_in low for 5 cycles mid-window with events present -> counters and timer zeroed. After enable returns high, the next boundary occurs exactly WINDOW_CYCLES cycles later and counts only post-enable events.
